// File: rtl/reg32_serializer_pkg.sv
// rtl/reg32_serializer_pkg.sv - shared state type and default width for the serializer
package reg_pkg;

    localparam int REG_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/reg32_serializer_if.sv
// rtl/reg32_serializer_if.sv - load handshake and serial output bundle
interface reg32_serializer_if
    import reg_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
);
    localparam int IW = $clog2(WIDTH);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             en;
    logic             serial_out;
    logic             serial_valid;
    logic             frame_start;
    logic             frame_end;
    logic [IW-1:0]    bit_index;

    // Upstream producer / downstream consumer side
    modport master (
        output load_valid, data_in, en,
        input  load_ready, serial_out, serial_valid, frame_start, frame_end, bit_index
    );

    // Serializer side
    modport slave (
        input  load_valid, data_in, en,
        output load_ready, serial_out, serial_valid, frame_start, frame_end, bit_index
    );

endinterface

// File: rtl/reg32_serializer_bit_down_counter.sv
// rtl/reg32_serializer_bit_down_counter.sv - loadable down-counter with zero flag
module bit_down_counter #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement; clear is handled in the register
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/reg32_serializer.sv
// rtl/reg32_serializer.sv - parallel-in serial-out unloader with frame markers
module reg32_serializer
    import reg_pkg::*;
#(
    parameter int WIDTH     = REG_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    reg32_serializer_if.slave bus
);

    localparam int            IW      = $clog2(WIDTH);
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic [IW-1:0]    cnt;
    logic             cnt_zero;
    logic             load_ready;
    logic             load_fire;
    logic             in_shift;

    bit_down_counter #(
        .W (IW)
    ) u_bit_cnt (
        .clk_i      (clk_i),
        .clr_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (TOP_IDX),
        .dec_i      (cnt_dec),
        .count_o    (cnt),
        .zero_o     (cnt_zero)
    );

    // Ready when idle, or when the last bit is being consumed so frames abut
    assign load_ready = !rst_i && ((state_q == IDLE) || (cnt_zero && bus.en));
    assign load_fire  = bus.load_valid && load_ready;

    // Next state, shift register and counter controls
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (load_fire) begin
            state_d  = SHIFT;
            shreg_d  = bus.data_in;
            cnt_load = 1'b1;
        end else if ((state_q == SHIFT) && bus.en) begin
            if (!cnt_zero) begin
                cnt_dec = 1'b1;
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                end
            end else begin
                state_d = IDLE;
                shreg_d = '0;
            end
        end
    end

    // State and shift register; reset drops any word in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

    assign in_shift         = (state_q == SHIFT);
    assign bus.load_ready   = load_ready;
    assign bus.serial_valid = in_shift;
    assign bus.serial_out   = in_shift && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign bus.frame_start  = in_shift && (cnt == TOP_IDX);
    assign bus.frame_end    = in_shift && cnt_zero;
    assign bus.bit_index    = cnt;

endmodule

// File: tb/tb_reg32_serializer.sv
// tb/tb_reg32_serializer.sv - self-checking bench for reg32_serializer
module tb_reg32_serializer;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    reg32_serializer_if #(.WIDTH(32)) bus1 ();
    reg32_serializer_if #(.WIDTH(32)) bus2 ();

    reg32_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    reg32_serializer #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    typedef struct {
        logic        rst;
        logic        lv;
        logic        en;
        logic [31:0] data;
        logic        exp_ready;
        logic        exp_so;
        logic        exp_sv;
        logic        exp_fs;
        logic        exp_fe;
        logic [4:0]  exp_idx;
    } vec_t;

    vec_t vecs[34];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic so, input logic sv,
                           input logic fs, input logic fe, input logic [4:0] idx);
        chk({tag, ".serial_out"},   bus1.serial_out,   so);
        chk({tag, ".serial_valid"}, bus1.serial_valid, sv);
        chk({tag, ".frame_start"},  bus1.frame_start,  fs);
        chk({tag, ".frame_end"},    bus1.frame_end,    fe);
        chk({tag, ".bit_index"},    bus1.bit_index,    idx);
    endtask

    initial begin
        logic [31:0] w;
        int          e;
        bit          seen_fe;

        w = 32'hA5A5_0001;
        rst = 1'b1;
        bus1.load_valid = 1'b0; bus1.data_in = '0; bus1.en = 1'b0;
        bus2.load_valid = 1'b0; bus2.data_in = '0; bus2.en = 1'b0;

        // reset state
        tick();
        bus1.load_valid = 1'b1;
        #1;
        chk("rst.load_ready", bus1.load_ready, 1'b0);
        tick();
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        bus1.load_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst.load_ready", bus1.load_ready, 1'b1);

        // table: one full frame at En=1, then return to idle
        for (int i = 0; i < 32; i++) begin
            vecs[i] = '{rst: 1'b0, lv: (i == 0), en: 1'b1, data: w,
                        exp_ready: (i == 0), exp_so: w[31-i], exp_sv: 1'b1,
                        exp_fs: (i == 0), exp_fe: (i == 31), exp_idx: 5'(31 - i)};
        end
        vecs[32] = '{rst: 1'b0, lv: 1'b0, en: 1'b1, data: w, exp_ready: 1'b1, exp_so: 1'b0,
                     exp_sv: 1'b0, exp_fs: 1'b0, exp_fe: 1'b0, exp_idx: 5'd0};
        vecs[33] = '{rst: 1'b0, lv: 1'b0, en: 1'b0, data: w, exp_ready: 1'b1, exp_so: 1'b0,
                     exp_sv: 1'b0, exp_fs: 1'b0, exp_fe: 1'b0, exp_idx: 5'd0};
        for (int i = 0; i < 34; i++) begin
            rst = vecs[i].rst;
            bus1.load_valid = vecs[i].lv;
            bus1.data_in = vecs[i].data;
            bus1.en = vecs[i].en;
            #1;
            chk($sformatf("vec%0d.load_ready", i), bus1.load_ready, vecs[i].exp_ready);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_so, vecs[i].exp_sv,
                    vecs[i].exp_fs, vecs[i].exp_fe, vecs[i].exp_idx);
        end

        // stall: En=0 for 3 cycles after bit 5
        bus1.load_valid = 1'b1; bus1.data_in = w; bus1.en = 1'b1;
        tick();
        bus1.load_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_out("stall.bit5", w[26], 1'b1, 1'b0, 1'b0, 5'd26);
        bus1.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d.load_ready", i), bus1.load_ready, 1'b0);
            tick();
            chk_out($sformatf("stall%0d", i), w[26], 1'b1, 1'b0, 1'b0, 5'd26);
        end
        bus1.en = 1'b1;
        e = 8;
        seen_fe = 1'b0;
        for (int i = 0; i < 40 && !seen_fe; i++) begin
            tick();
            e++;
            seen_fe = bus1.frame_end;
        end
        chk("stall.frame_end_seen", seen_fe, 1'b1);
        chk("stall.frame_end_edge", e, 34);
        chk("stall.last_bit", bus1.serial_out, w[0]);
        tick();
        chk("stall.idle_valid", bus1.serial_valid, 1'b0);

        // back-to-back frames with Load_valid held
        bus1.load_valid = 1'b1; bus1.data_in = 32'hFFFF_FFFF; bus1.en = 1'b1;
        tick();
        bus1.data_in = 32'h0000_0000;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) begin
                #1;
                chk($sformatf("b2b%0d.load_ready", i), bus1.load_ready, (i == 32));
                tick();
            end
            if (i == 32) bus1.load_valid = 1'b0;
            chk_out($sformatf("b2b%0d", i), (i < 32), 1'b1, (i == 0 || i == 32),
                    (i == 31 || i == 63), 5'(31 - (i % 32)));
        end
        tick();
        chk("b2b.idle_valid", bus1.serial_valid, 1'b0);

        // load pulse while busy is ignored
        bus1.load_valid = 1'b1; bus1.data_in = w;
        tick();
        bus1.load_valid = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        chk("ign.bit_index", bus1.bit_index, 5'd10);
        bus1.load_valid = 1'b1; bus1.data_in = 32'h1234_5678;
        #1;
        chk("ign.load_ready", bus1.load_ready, 1'b0);
        tick();
        bus1.load_valid = 1'b0;
        for (int i = 22; i < 32; i++) begin
            if (i > 22) tick();
            chk_out($sformatf("ign%0d", i), w[31-i], 1'b1, 1'b0, (i == 31), 5'(31 - i));
        end
        tick();
        chk("ign.idle_valid", bus1.serial_valid, 1'b0);

        // reset mid-word at Bit_index=16, then a fresh load
        bus1.load_valid = 1'b1; bus1.data_in = w;
        tick();
        bus1.load_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("mrst.bit_index", bus1.bit_index, 5'd16);
        rst = 1'b1;
        bus1.load_valid = 1'b1; bus1.data_in = 32'h8000_0000;
        #1;
        chk("mrst.load_ready", bus1.load_ready, 1'b0);
        tick();
        chk_out("mrst.after", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        rst = 1'b0;
        #1;
        chk("mrst.ready_after", bus1.load_ready, 1'b1);
        tick();
        bus1.load_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) tick();
            chk_out($sformatf("mrst_ld%0d", i), (i == 0), 1'b1, (i == 0), (i == 31), 5'(31 - i));
        end
        tick();
        chk("mrst.idle_valid", bus1.serial_valid, 1'b0);

        // LSB-first instance
        bus2.load_valid = 1'b1; bus2.data_in = 32'h0000_0003; bus2.en = 1'b1;
        tick();
        bus2.load_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) tick();
            chk($sformatf("lsb%0d.serial_out", i), bus2.serial_out, (i < 2));
            chk($sformatf("lsb%0d.frame_end", i), bus2.frame_end, (i == 31));
        end
        tick();
        chk("lsb.idle_valid", bus2.serial_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
